// File: rtl/turn_timeout_ctrl.sv
// Player-turn controller: drives the turn timer's reset/enable, detects button presses
// against the expected symbol and reports WIN, FAIL or TIMEOUT over a SEQ_LEN-symbol round.
module turn_timeout_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int LIMIT    = 9,
  parameter int SEQ_LEN  = 8,
  parameter int IDXW     = 3
) (
  input  logic            CLKT,
  input  logic            R,
  input  logic            START,
  input  logic [3:0]      BTN,
  input  logic [3:0]      EXPECTED,
  input  logic [3:0]      TEMPO,
  input  logic            end_time,
  output logic            CNT_R,
  output logic            CNT_E,
  output logic [IDXW-1:0] IDX,
  output logic            HIT,
  output logic            WIN,
  output logic            FAIL,
  output logic            TIMEOUT,
  output logic [3:0]      TIME_LEFT,
  output logic [2:0]      state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_WIN   = 3'd4,
    S_FAIL  = 3'd5
  } state_t;

  localparam int                PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0]     PMAX    = PW'(TICK_DIV - 1);
  localparam logic [IDXW-1:0]   LAST    = IDXW'(SEQ_LEN - 1);
  localparam logic [3:0]        LIMIT_V = 4'(LIMIT);

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      btn_prev_q, btn_prev_d;
  logic [3:0]      vec_q, vec_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            hit_q, hit_d;
  logic            win_q, win_d;
  logic            fail_q, fail_d;
  logic            timeout_q, timeout_d;
  logic            cnt_r_q, cnt_r_d;
  logic            cnt_e_q, cnt_e_d;
  logic [3:0]      btn_edge;
  logic            match;

  always_ff @(posedge CLKT or negedge R) begin
    if (!R) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      btn_prev_q <= '0;
      vec_q      <= '0;
      idx_q      <= '0;
      hit_q      <= 1'b0;
      win_q      <= 1'b0;
      fail_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_r_q    <= 1'b1;
      cnt_e_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      btn_prev_q <= btn_prev_d;
      vec_q      <= vec_d;
      idx_q      <= idx_d;
      hit_q      <= hit_d;
      win_q      <= win_d;
      fail_q     <= fail_d;
      timeout_q  <= timeout_d;
      cnt_r_q    <= cnt_r_d;
      cnt_e_q    <= cnt_e_d;
    end
  end

  // A press is any new rising edge; a multi-bit edge can never match a one-hot symbol.
  assign btn_edge = BTN & ~btn_prev_q;
  assign match    = (vec_q == EXPECTED) && (vec_q != 4'd0) &&
                    ((vec_q & (vec_q - 4'd1)) == 4'd0);

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    btn_prev_d = BTN;
    vec_d      = vec_q;
    idx_d      = idx_q;
    hit_d      = 1'b0;
    win_d      = win_q;
    fail_d     = fail_q;
    timeout_d  = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_ARM;
          idx_d   = '0;
        end
      end
      S_ARM: begin
        presc_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        presc_d = (presc_q == PMAX) ? '0 : presc_q + PW'(1);
        if (|btn_edge) begin
          vec_d   = btn_edge;
          state_d = S_CHECK;
        end else if (end_time) begin
          state_d   = S_FAIL;
          fail_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      S_CHECK: begin
        if (match) begin
          hit_d = 1'b1;
          if (idx_q == LAST) begin
            state_d = S_WIN;
            win_d   = 1'b1;
          end else begin
            idx_d   = idx_q + IDXW'(1);
            state_d = S_ARM;
          end
        end else begin
          state_d   = S_FAIL;
          fail_d    = 1'b1;
          timeout_d = 1'b0;
        end
      end
      S_WIN, S_FAIL: begin
        if (START) begin
          state_d   = S_ARM;
          idx_d     = '0;
          win_d     = 1'b0;
          fail_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Strobe suppressed if the turn leaves WAIT so CHECK never sees CNT_E.
    cnt_e_d = (state_q == S_WAIT) && (state_d == S_WAIT) && (presc_q == PMAX);
    cnt_r_d = !((state_d == S_WAIT) || (state_d == S_CHECK));
  end

  assign CNT_R     = cnt_r_q;
  assign CNT_E     = cnt_e_q;
  assign IDX       = idx_q;
  assign HIT       = hit_q;
  assign WIN       = win_q;
  assign FAIL      = fail_q;
  assign TIMEOUT   = timeout_q;
  assign TIME_LEFT = (TEMPO > LIMIT_V) ? 4'd0 : (LIMIT_V - TEMPO);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_turn_timeout_ctrl.sv
// Bench for turn_timeout_ctrl with a behavioural model of the 4-bit turn timer.
module tb_turn_timeout_ctrl;

  localparam int TICK_DIV = 4;
  localparam int LIMIT    = 9;
  localparam int SEQ_LEN  = 3;
  localparam int IDXW     = 2;

  logic       CLKT = 1'b0;
  logic       R = 1'b0;
  logic       START = 1'b0;
  logic [3:0] BTN = 4'd0;
  logic [3:0] EXPECTED = 4'd0;
  logic [3:0] TEMPO;
  logic       end_time;
  logic       CNT_R, CNT_E, HIT, WIN, FAIL, TIMEOUT;
  logic [IDXW-1:0] IDX;
  logic [3:0] TIME_LEFT;
  logic [2:0] state_dbg;

  // timer model plus force overrides for directed corner cases
  logic [3:0] tempo_m;
  logic       end_m;
  logic       tempo_force = 1'b0;
  logic [3:0] tempo_force_val = 4'd0;
  logic       end_force = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [IDXW-1:0] exp_q[$];

  assign TEMPO    = tempo_force ? tempo_force_val : tempo_m;
  assign end_time = end_force ? 1'b1 : end_m;

  turn_timeout_ctrl #(
    .TICK_DIV(TICK_DIV), .LIMIT(LIMIT), .SEQ_LEN(SEQ_LEN), .IDXW(IDXW)
  ) dut (
    .CLKT(CLKT), .R(R), .START(START), .BTN(BTN), .EXPECTED(EXPECTED),
    .TEMPO(TEMPO), .end_time(end_time), .CNT_R(CNT_R), .CNT_E(CNT_E),
    .IDX(IDX), .HIT(HIT), .WIN(WIN), .FAIL(FAIL), .TIMEOUT(TIMEOUT),
    .TIME_LEFT(TIME_LEFT), .state_dbg(state_dbg)
  );

  always #5 CLKT = ~CLKT;

  always @(posedge CLKT or posedge CNT_R) begin
    if (CNT_R) begin
      tempo_m <= 4'd0;
      end_m   <= 1'b0;
    end else if (CNT_E) begin
      if (tempo_m == 4'(LIMIT)) begin
        tempo_m <= 4'd0;
        end_m   <= 1'b1;
      end else begin
        tempo_m <= tempo_m + 4'd1;
        end_m   <= 1'b0;
      end
    end else begin
      end_m <= 1'b0;
    end
  end

  // Scoreboard: every HIT pulse must match a queued expected post-hit IDX.
  always @(negedge CLKT) begin
    if (R && HIT === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_hit act_idx=%0d exp=none", IDX);
      end else begin
        logic [IDXW-1:0] e;
        e = exp_q.pop_front();
        if (IDX !== e) begin
          failures++;
          $display("FAIL hit_idx act=%0d exp=%0d", IDX, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLKT);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic wait_wait();
    int n = 0;
    while (CNT_R !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    if (CNT_R !== 1'b0) chk("wait_entry_timeout", CNT_R, 0);
  endtask

  task automatic start_round();
    START = 1'b1;
    tick();
    START = 1'b0;
    chk("start_win_clr", WIN, 0);
    chk("start_fail_clr", FAIL, 0);
    chk("start_to_clr", TIMEOUT, 0);
    chk("start_idx", IDX, 0);
    chk("start_cnt_r", CNT_R, 1);
  endtask

  typedef struct {
    logic [3:0] tempo;
    logic [3:0] exp_tl;
  } tl_vec_t;

  typedef struct {
    logic            do_start;
    logic [3:0]      sym;
    logic [3:0]      btn;
    logic            exp_hit;
    logic [IDXW-1:0] exp_idx;
    logic            exp_win;
    logic            exp_fail;
    logic            exp_to;
  } press_vec_t;

  tl_vec_t    tl_tab[7];
  press_vec_t pv[6];

  initial begin
    int c;
    int k;
    int fail_c;
    logic [3:0] tmax;

    tl_tab[0] = '{4'd0,  4'd9};
    tl_tab[1] = '{4'd1,  4'd8};
    tl_tab[2] = '{4'd5,  4'd4};
    tl_tab[3] = '{4'd9,  4'd0};
    tl_tab[4] = '{4'd10, 4'd0};
    tl_tab[5] = '{4'd12, 4'd0};
    tl_tab[6] = '{4'd15, 4'd0};

    pv[0] = '{1'b1, 4'b0001, 4'b0001, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0};
    pv[1] = '{1'b0, 4'b0010, 4'b0010, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0};
    pv[2] = '{1'b0, 4'b0100, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0};
    pv[3] = '{1'b1, 4'b0010, 4'b0011, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
    pv[4] = '{1'b1, 4'b1000, 4'b1000, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0};
    pv[5] = '{1'b0, 4'b0001, 4'b0010, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0};

    // reset and idle
    repeat (3) tick();
    R = 1'b1;
    repeat (20) tick();
    chk("idle_cnt_r", CNT_R, 1);
    chk("idle_cnt_e", CNT_E, 0);
    chk("idle_idx", IDX, 0);
    chk("idle_hit", HIT, 0);
    chk("idle_win", WIN, 0);
    chk("idle_fail", FAIL, 0);
    chk("idle_to", TIMEOUT, 0);
    chk("idle_time_left", TIME_LEFT, 9);

    // TIME_LEFT saturation table
    tempo_force = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tempo_force_val = tl_tab[i].tempo;
      #1;
      chk($sformatf("time_left_t%0d", tl_tab[i].tempo), TIME_LEFT, tl_tab[i].exp_tl);
    end
    tempo_force = 1'b0;

    // press table: a full win, a multi-bit miss, a miss at IDX=1
    for (int i = 0; i < 6; i++) begin
      if (pv[i].do_start) start_round();
      wait_wait();
      repeat (9) tick();
      EXPECTED = pv[i].sym;
      BTN      = pv[i].btn;
      if (pv[i].exp_hit) exp_q.push_back(pv[i].exp_idx);
      tick();
      tick();
      chk($sformatf("v%0d_hit", i), HIT, pv[i].exp_hit);
      chk($sformatf("v%0d_idx", i), IDX, pv[i].exp_idx);
      chk($sformatf("v%0d_win", i), WIN, pv[i].exp_win);
      chk($sformatf("v%0d_fail", i), FAIL, pv[i].exp_fail);
      chk($sformatf("v%0d_to", i), TIMEOUT, pv[i].exp_to);
      chk($sformatf("v%0d_cnt_r", i), CNT_R, 1);
      tick();
      chk($sformatf("v%0d_hit_width", i), HIT, 0);
      BTN = 4'd0;
    end
    repeat (5) tick();
    chk("fail_held", FAIL, 1);

    // timeout: strobe period, TEMPO sweep, FAIL latency from WAIT entry
    start_round();
    wait_wait();
    c = 0;
    k = 0;
    fail_c = 0;
    tmax = 4'd0;
    while (FAIL !== 1'b1 && c < 60) begin
      tick();
      c++;
      if (TEMPO > tmax) tmax = TEMPO;
      if (CNT_E === 1'b1) begin
        k++;
        chk($sformatf("cnt_e_at_%0d", k), c, 4 * k);
      end
    end
    fail_c = c;
    checks++;
    if (fail_c < 40 || fail_c > 42) begin
      failures++;
      $display("FAIL timeout_latency act=%0d exp=40..42", fail_c);
    end
    chk("timeout_strobes", k, 10);
    chk("timeout_tempo_max", tmax, 9);
    chk("timeout_fail", FAIL, 1);
    chk("timeout_flag", TIMEOUT, 1);
    chk("timeout_cnt_r", CNT_R, 1);

    // press and end_time in the same cycle: press wins; held BTN is not a new press
    start_round();
    wait_wait();
    repeat (9) tick();
    EXPECTED  = 4'b0001;
    BTN       = 4'b0001;
    end_force = 1'b1;
    exp_q.push_back(2'd1);
    tick();
    end_force = 1'b0;
    tick();
    chk("race_hit", HIT, 1);
    chk("race_idx", IDX, 1);
    chk("race_fail", FAIL, 0);
    repeat (14) tick();
    chk("hold_idx", IDX, 1);
    chk("hold_fail", FAIL, 0);
    chk("hold_in_wait", CNT_R, 0);
    BTN = 4'd0;

    // START in WAIT ignored, then async reset mid-WAIT
    tick();
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    chk("start_ignored_idx", IDX, 1);
    chk("start_ignored_cnt_r", CNT_R, 0);
    R = 1'b0;
    #1;
    chk("areset_idx", IDX, 0);
    chk("areset_cnt_r", CNT_R, 1);
    chk("areset_fail", FAIL, 0);
    repeat (2) tick();
    R = 1'b1;
    repeat (3) tick();
    chk("post_reset_idle", CNT_R, 1);
    chk("post_reset_idx", IDX, 0);

    chk("hit_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
